// File: rtl/core_run_ctrl.sv
// core_run_ctrl: reset/run/single-step sequencer for a group of processor cores with halt and step-budget termination
module core_run_ctrl #(
    parameter int N_CORES    = 1,
    parameter int RST_CYCLES = 1,
    parameter int MAX_STEPS  = 200,
    parameter int CNT_W      = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_step_mode,
    input  logic               i_step_req,
    input  logic [N_CORES-1:0] i_halt,
    output logic               o_core_rst,
    output logic               o_core_en,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_timeout,
    output logic [N_CORES-1:0] o_halted,
    output logic [CNT_W-1:0]   o_cycle_cnt
);
    localparam int RW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
    typedef enum logic [2:0] {IDLE, RESET, RUN, STEP_WAIT, DONE} state_t;
    state_t        state;
    logic [RW-1:0] rcnt;
    logic          last;
    // the enabled cycle in progress is the final one the budget allows
    assign last = MAX_STEPS != 0 && o_cycle_cnt == CNT_W'(MAX_STEPS - 1);
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            rcnt        <= '0;
            o_core_rst  <= 1'b1;
            o_core_en   <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_timeout   <= 1'b0;
            o_halted    <= '0;
            o_cycle_cnt <= '0;
        end else begin
            if (o_core_en)
                o_cycle_cnt <= &o_cycle_cnt ? o_cycle_cnt : o_cycle_cnt + 1'b1;
            case (state)
                IDLE, DONE: if (i_start) begin
                    state       <= RESET;
                    rcnt        <= '0;
                    o_core_rst  <= 1'b1;
                    o_busy      <= 1'b1;
                    o_done      <= 1'b0;
                    o_timeout   <= 1'b0;
                    o_halted    <= '0;
                    o_cycle_cnt <= '0;
                end
                RESET: if (rcnt == RW'(RST_CYCLES - 1)) begin
                    state      <= i_step_mode ? STEP_WAIT : RUN;
                    o_core_rst <= 1'b0;
                    o_core_en  <= !i_step_mode;
                end else begin
                    rcnt <= rcnt + 1'b1;
                end
                default: if (o_core_en && |i_halt) begin
                    state     <= DONE;
                    o_core_en <= 1'b0;
                    o_busy    <= 1'b0;
                    o_done    <= 1'b1;
                    o_halted  <= i_halt;
                end else if (o_core_en && last) begin
                    state     <= DONE;
                    o_core_en <= 1'b0;
                    o_busy    <= 1'b0;
                    o_done    <= 1'b1;
                    o_timeout <= 1'b1;
                end else if (i_step_mode) begin
                    state     <= STEP_WAIT;
                    o_core_en <= state == STEP_WAIT && i_step_req;
                end else begin
                    state     <= RUN;
                    o_core_en <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: two differently parameterised instances driven in lockstep, checked against a phase-level model
module tb_core_run_ctrl;
    logic clk = 0, rst = 1, start = 0, step_mode = 0, step_req = 0;
    logic [1:0] ha = 0;
    logic       hb = 0;
    logic a_rst, a_en, a_busy, a_done, a_to, b_rst, b_en, b_busy, b_done, b_to, b_hal;
    logic [1:0] a_hal;
    logic [4:0] a_cnt;
    logic [2:0] b_cnt;
    int total = 0, bad = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;

    core_run_ctrl #(.N_CORES(2), .RST_CYCLES(3), .MAX_STEPS(20), .CNT_W(5)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_step_mode(step_mode), .i_step_req(step_req),
        .i_halt(ha), .o_core_rst(a_rst), .o_core_en(a_en), .o_busy(a_busy), .o_done(a_done),
        .o_timeout(a_to), .o_halted(a_hal), .o_cycle_cnt(a_cnt));
    core_run_ctrl #(.N_CORES(1), .RST_CYCLES(1), .MAX_STEPS(0), .CNT_W(3)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_step_mode(step_mode), .i_step_req(step_req),
        .i_halt(hb), .o_core_rst(b_rst), .o_core_en(b_en), .o_busy(b_busy), .o_done(b_done),
        .o_timeout(b_to), .o_halted(b_hal), .o_cycle_cnt(b_cnt));

    // model phases: 0 idle, 1 core reset, 2 free run, 3 step wait, 4 done
    int         ph[2] = '{0, 0}, rl[2] = '{0, 0}, cn[2] = '{0, 0};
    bit         en_m[2] = '{0, 0}, to_m[2] = '{0, 0};
    logic [1:0] hl[2] = '{0, 0};
    int         pr[2] = '{3, 1}, pm[2] = '{20, 0}, pc[2] = '{31, 7};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [1:0] h;
            h = i == 0 ? ha : {1'b0, hb};
            if (rst) begin
                ph[i] = 0; en_m[i] = 0; cn[i] = 0; to_m[i] = 0; hl[i] = 0;
            end else if (ph[i] == 0 || ph[i] == 4) begin
                if (start) begin
                    ph[i] = 1; rl[i] = pr[i]; cn[i] = 0; to_m[i] = 0; hl[i] = 0;
                end
            end else if (ph[i] == 1) begin
                rl[i]--;
                if (rl[i] == 0) begin
                    ph[i] = step_mode ? 3 : 2;
                    en_m[i] = !step_mode;
                end
            end else begin
                if (en_m[i]) begin
                    cn[i] = cn[i] + 1 > pc[i] ? pc[i] : cn[i] + 1;
                    if (h != 0) begin
                        ph[i] = 4; hl[i] = h; en_m[i] = 0;
                    end else if (pm[i] > 0 && cn[i] == pm[i]) begin
                        ph[i] = 4; to_m[i] = 1; en_m[i] = 0;
                    end
                end
                if (ph[i] != 4) begin
                    if (step_mode) begin
                        en_m[i] = ph[i] == 3 && step_req;
                        ph[i] = 3;
                    end else begin
                        ph[i] = 2; en_m[i] = 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    logic [1:0]  d_rst, d_en, d_busy, d_done, d_to;
    logic [1:0]  d_hal[2];
    logic [31:0] d_cnt[2];
    assign d_rst = {b_rst, a_rst};
    assign d_en = {b_en, a_en};
    assign d_busy = {b_busy, a_busy};
    assign d_done = {b_done, a_done};
    assign d_to = {b_to, a_to};
    assign d_hal[0] = a_hal;
    assign d_hal[1] = {1'b0, b_hal};
    assign d_cnt[0] = 32'(a_cnt);
    assign d_cnt[1] = 32'(b_cnt);

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                chk("core_rst", i, 32'(d_rst[i]), 32'(ph[i] <= 1));
                chk("core_en", i, 32'(d_en[i]), 32'(en_m[i]));
                chk("busy", i, 32'(d_busy[i]), 32'(ph[i] >= 1 && ph[i] <= 3));
                chk("done", i, 32'(d_done[i]), 32'(ph[i] == 4));
                chk("timeout", i, 32'(d_to[i]), 32'(to_m[i]));
                chk("halted", i, 32'(d_hal[i]), 32'(hl[i]));
                chk("cycle_cnt", i, d_cnt[i], cn[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int target);
        int n = 0;
        while (32'(a_cnt) != target && n < 200) begin
            tick();
            n++;
        end
        chk("wait_cnt", 0, 32'(a_cnt), target);
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    initial begin
        int n;
        tick();
        chk_on = 1;
        tick();
        rst = 0;
        chk("idle_rst", 0, 32'(a_rst), 1);
        chk("idle_en", 0, 32'(a_en), 0);
        chk("idle_busy", 0, 32'(a_busy), 0);
        chk("idle_cnt", 0, 32'(a_cnt), 0);
        // free run to budget; B has no budget and saturates
        pulse_start();
        n = 0;
        while (a_rst && n < 20) begin
            n++;
            tick();
        end
        chk("rst_len", 0, n, 3);
        n = 0;
        while (!a_done && n < 200) begin
            n++;
            tick();
        end
        chk("to_done", 0, 32'(a_done), 1);
        chk("to_cnt", 0, 32'(a_cnt), 20);
        chk("to_flag", 0, 32'(a_to), 1);
        chk("to_hal", 0, 32'(a_hal), 0);
        chk("sat_cnt", 1, 32'(b_cnt), 7);
        chk("sat_busy", 1, 32'(b_busy), 1);
        hb = 1;
        tick();
        hb = 0;
        chk("b_halt_done", 1, 32'(b_done), 1);
        chk("b_halted", 1, 32'(b_hal), 1);
        chk("b_halt_to", 1, 32'(b_to), 0);
        // halt on the 17th enabled cycle
        pulse_start();
        chk("restart_flags", 1, 32'({b_hal, b_to, b_done}), 0);
        wait_cnt(16);
        ha = 2'b10;
        tick();
        ha = 0;
        chk("h17_done", 0, 32'(a_done), 1);
        chk("h17_hal", 0, 32'(a_hal), 2);
        chk("h17_to", 0, 32'(a_to), 0);
        chk("h17_cnt", 0, 32'(a_cnt), 17);
        // halt and budget exhaustion in the same cycle
        pulse_start();
        wait_cnt(19);
        ha = 2'b01;
        tick();
        ha = 0;
        chk("hb_done", 0, 32'(a_done), 1);
        chk("hb_hal", 0, 32'(a_hal), 1);
        chk("hb_to", 0, 32'(a_to), 0);
        chk("hb_cnt", 0, 32'(a_cnt), 20);
        // reset mid-run
        pulse_start();
        wait_cnt(10);
        rst = 1;
        tick();
        rst = 0;
        chk("mr_cnt", 0, 32'(a_cnt), 0);
        chk("mr_busy", 0, 32'(a_busy), 0);
        chk("mr_rst", 0, 32'(a_rst), 1);
        chk("mr_b", 1, 32'({b_busy, b_en, b_cnt}), 0);
        pulse_start();
        chk("mr_restart", 0, 32'({a_busy, a_cnt}), 32'h20);
        wait_cnt(5);
        rst = 1;
        tick();
        rst = 0;
        // step mode: one request during reset, then four spaced requests
        step_mode = 1;
        pulse_start();
        step_req = 1;
        tick();
        step_req = 0;
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            step_req = 1;
            tick();
            step_req = 0;
            repeat (2) tick();
        end
        chk("step_cnt", 0, 32'(a_cnt), 4);
        chk("step_cnt", 1, 32'(b_cnt), 4);
        chk("step_busy", 0, 32'(a_busy), 1);
        step_mode = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = $urandom_range(299) == 0;
            start = $urandom_range(14) == 0;
            if ($urandom_range(39) == 0) step_mode = ~step_mode;
            step_req = $urandom_range(2) == 0;
            ha = $urandom_range(24) == 0 ? 2'($urandom) : 2'b0;
            hb = $urandom_range(24) == 0;
            tick();
        end
        rst = 0;
        start = 0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
